// File: rtl/uart_pkg.sv
// Shared UART receive definitions: parity encodings, frame-checker states, error flag indices
// and the parity helper functions.
package uart_pkg;

  localparam logic [1:0] NOPARITY00 = 2'b00;
  localparam logic [1:0] ODD        = 2'b01;
  localparam logic [1:0] EVEN       = 2'b10;
  localparam logic [1:0] NOPARITY11 = 2'b11;

  localparam int ERR_PARITY = 0;
  localparam int ERR_START  = 1;
  localparam int ERR_STOP   = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP1  = 3'd3,
    ST_STOP2  = 3'd4
  } state_t;

  function automatic logic has_parity(input logic [1:0] ptype);
    return (ptype == ODD) || (ptype == EVEN);
  endfunction

  // Expected parity bit given the running XOR of the data bits.
  function automatic logic parity_expected(input logic [1:0] ptype, input logic data_xor);
    return (ptype == ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_err_counter.sv
// Saturating error event counter with synchronous clear; clear beats a same-cycle increment.
module uart_err_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frame_checker.sv
// Frame checker for the frame-aligned Rx bit stream: deserialises LSB first, checks start,
// parity and stop bits. Optional error counters are built when UART_ERR_CNT_EN is defined.
module uart_rx_frame_checker
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic [1:0]        parity_type,
  input  logic              stop_bits,
  input  logic              abort,
  output logic              busy,
  output logic              frame_valid,
  output logic [DATA_W-1:0] data_out,
  output logic [2:0]        error_flag
`ifdef UART_ERR_CNT_EN
  ,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  parity_err_cnt,
  output logic [CNT_W-1:0]  start_err_cnt,
  output logic [CNT_W-1:0]  stop_err_cnt
`endif
);

  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [BCW-1:0]    bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [1:0]        ptype_q;
  logic              stop2_q;
  logic              par_acc;
  logic              par_err;
  logic              start_err;
  logic              stop_err;
  logic              accept;
  logic              done;

  assign accept = bit_valid && !abort;
  assign busy   = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else if (bit_valid) begin
      case (state)
        ST_IDLE:   state_nxt = ST_DATA;
        ST_DATA:   if (bit_cnt == BIT_LAST)
                     state_nxt = has_parity(ptype_q) ? ST_PARITY : ST_STOP1;
        ST_PARITY: state_nxt = ST_STOP1;
        ST_STOP1: begin
          if (stop2_q) begin
            state_nxt = ST_STOP2;
          end else begin
            state_nxt = ST_IDLE;
            done      = 1'b1;
          end
        end
        ST_STOP2: begin
          state_nxt = ST_IDLE;
          done      = 1'b1;
        end
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      ptype_q     <= NOPARITY00;
      stop2_q     <= 1'b0;
      par_acc     <= 1'b0;
      par_err     <= 1'b0;
      start_err   <= 1'b0;
      stop_err    <= 1'b0;
      frame_valid <= 1'b0;
      data_out    <= '0;
      error_flag  <= '0;
    end else begin
      state       <= state_nxt;
      frame_valid <= 1'b0;
      if (accept) begin
        case (state)
          ST_IDLE: begin
            // Frame mode is frozen at the start bit; a bad start still consumes the frame.
            ptype_q   <= parity_type;
            stop2_q   <= stop_bits;
            start_err <= bit_in;
            par_err   <= 1'b0;
            stop_err  <= 1'b0;
            par_acc   <= 1'b0;
            bit_cnt   <= '0;
          end
          ST_DATA: begin
            shift_reg <= {bit_in, shift_reg[DATA_W-1:1]};
            par_acc   <= par_acc ^ bit_in;
            bit_cnt   <= bit_cnt + BCW'(1);
          end
          ST_PARITY: par_err  <= (bit_in != parity_expected(ptype_q, par_acc));
          ST_STOP1:  stop_err <= stop_err | ~bit_in;
          default: ;
        endcase
      end
      if (done) begin
        frame_valid            <= 1'b1;
        data_out               <= shift_reg;
        error_flag[ERR_PARITY] <= par_err;
        error_flag[ERR_START]  <= start_err;
        error_flag[ERR_STOP]   <= stop_err | ~bit_in;
      end
    end
  end

`ifdef UART_ERR_CNT_EN
  uart_err_counter #(.CNT_W(CNT_W)) u_parity_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .inc     (frame_valid && error_flag[ERR_PARITY]),
    .count   (parity_err_cnt)
  );

  uart_err_counter #(.CNT_W(CNT_W)) u_start_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .inc     (frame_valid && error_flag[ERR_START]),
    .count   (start_err_cnt)
  );

  uart_err_counter #(.CNT_W(CNT_W)) u_stop_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .inc     (frame_valid && error_flag[ERR_STOP]),
    .count   (stop_err_cnt)
  );
`endif

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Randomised bench for uart_rx_frame_checker with a frame-level reference model;
// the counter section is compiled when UART_ERR_CNT_EN is defined.
module tb_uart_rx_frame_checker;

  localparam int DW = 8;
  localparam int CW = 2;
  localparam logic [1:0] P_NONE = 2'b00, P_ODD = 2'b01, P_EVEN = 2'b10, P_NONE3 = 2'b11;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_in = 1'b0;
  logic [1:0]    parity_type = 2'b00;
  logic          stop_bits = 1'b0;
  logic          abort = 1'b0;
  logic          busy;
  logic          frame_valid;
  logic [DW-1:0] data_out;
  logic [2:0]    error_flag;
`ifdef UART_ERR_CNT_EN
  logic          cnt_clear = 1'b0;
  logic [CW-1:0] parity_err_cnt, start_err_cnt, stop_err_cnt;
`endif

  uart_rx_frame_checker #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
    .abort       (abort),
    .busy        (busy),
    .frame_valid (frame_valid),
    .data_out    (data_out),
    .error_flag  (error_flag)
`ifdef UART_ERR_CNT_EN
    ,
    .cnt_clear      (cnt_clear),
    .parity_err_cnt (parity_err_cnt),
    .start_err_cnt  (start_err_cnt),
    .stop_err_cnt   (stop_err_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] d;
    logic [2:0]    f;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_fv  = 0;
  int   n_exp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every completed frame is matched in order against the model's expected results.
  exp_t mon_e;
  always @(posedge clock) begin
    #1;
    if (frame_valid === 1'b1) begin
      n_fv++;
      if (exp_q.size() == 0) begin
        chk("spurious_frame_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("data_out", 32'(data_out), 32'(mon_e.d));
        chk("error_flag", 32'(error_flag), 32'(mon_e.f));
      end
    end
  end

  function automatic int rgap(input int maxgap);
    return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
  endfunction

  task automatic strobe(input logic b, input int gap);
    bit_valid = 1'b1;
    bit_in    = b;
    @(negedge clock);
    bit_valid = 1'b0;
    bit_in    = 1'($urandom);
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic [1:0] pt, input logic s2,
                            input logic start_b, input logic pflip, input logic st1,
                            input logic st2, input int maxgap, input int tail,
                            input logic scramble);
    logic has_p;
    logic pbit;
    logic [2:0] f;
    exp_t e;
    has_p = (pt == P_ODD) || (pt == P_EVEN);
    // Even parity makes the total count of ones even; odd makes it odd.
    pbit  = (pt == P_EVEN) ? logic'($countones(d) % 2) : logic'(1 - ($countones(d) % 2));
    f[0]  = has_p && pflip;
    f[1]  = start_b;
    f[2]  = !st1 || (s2 && !st2);
    e.d = d;
    e.f = f;
    exp_q.push_back(e);
    n_exp++;
    parity_type = pt;
    stop_bits   = s2;
    strobe(start_b, rgap(maxgap));
    chk("busy_in_frame", 32'(busy), 32'd1);
    if (scramble) begin
      parity_type = 2'($urandom);
      stop_bits   = 1'($urandom);
    end
    for (int i = 0; i < DW; i++) strobe(d[i], rgap(maxgap));
    if (has_p) strobe(pbit ^ pflip, rgap(maxgap));
    if (s2) strobe(st1, rgap(maxgap));
    bit_valid = 1'b1;
    bit_in    = s2 ? st2 : st1;
    @(negedge clock);
    chk("frame_valid_latency", 32'(frame_valid), 32'd1);
    chk("busy_after_frame", 32'(busy), 32'd0);
    bit_valid = 1'b0;
    repeat (tail) @(negedge clock);
  endtask

  logic [DW-1:0] prev_d;
  logic [2:0]    prev_f;

  initial begin
    repeat (3) @(negedge clock);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_frame_valid", 32'(frame_valid), 32'd0);
    chk("reset_data_out", 32'(data_out), 32'd0);
    chk("reset_error_flag", 32'(error_flag), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    send_frame(8'hA5, P_EVEN, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 3, 1'b0);
    chk("data_hold", 32'(data_out), 32'hA5);

    send_frame(8'h01, P_ODD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 2, 1'b0);
    send_frame(8'h01, P_ODD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 2, 1'b0);

    send_frame(8'h5A, P_NONE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 2, 1'b0);
    send_frame(8'hC3, P_NONE3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 2, 1'b0);

    // Abort at data bit 4 together with a strobe: the strobe must be dropped.
    prev_d = data_out;
    prev_f = error_flag;
    parity_type = P_EVEN;
    stop_bits   = 1'b0;
    strobe(1'b0, 0);
    for (int i = 0; i < 4; i++) strobe(1'($urandom), 0);
    abort     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    @(negedge clock);
    abort     = 1'b0;
    bit_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_data_held", 32'(data_out), 32'(prev_d));
    chk("abort_flags_held", 32'(error_flag), 32'(prev_f));
    @(negedge clock);
    send_frame(8'h3C, P_EVEN, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 2, 1'b0);

    // Mode inputs scrambled mid-frame, two frames with no gap cycle.
    send_frame(8'h96, P_ODD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b1);
    send_frame(8'h7E, P_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 2, 1'b1);

    // Reset in the middle of a frame discards it and clears the outputs.
    parity_type = P_EVEN;
    strobe(1'b0, 0);
    for (int i = 0; i < 3; i++) strobe(1'b1, 0);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_data_out", 32'(data_out), 32'd0);
    chk("midreset_error_flag", 32'(error_flag), 32'd0);
    send_frame(8'hE1, P_EVEN, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      send_frame(8'($urandom), 2'($urandom), 1'($urandom),
                 $urandom_range(7, 0) == 0, $urandom_range(3, 0) == 0,
                 $urandom_range(5, 0) != 0, $urandom_range(5, 0) != 0,
                 int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), 1'($urandom));
    end
    repeat (2) @(negedge clock);

`ifdef UART_ERR_CNT_EN
    cnt_clear = 1'b1;
    @(negedge clock);
    cnt_clear = 1'b0;
    chk("cnt_cleared_stop", 32'(stop_err_cnt), 32'd0);
    chk("cnt_cleared_start", 32'(start_err_cnt), 32'd0);
    for (int n = 0; n < 5; n++)
      send_frame(8'($urandom), P_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0);
    @(negedge clock);
    chk("stop_cnt_saturated", 32'(stop_err_cnt), 32'd3);
    chk("parity_cnt_idle", 32'(parity_err_cnt), 32'd0);
    chk("start_cnt_idle", 32'(start_err_cnt), 32'd0);
    send_frame(8'h11, P_EVEN, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 2, 1'b0);
    chk("start_cnt_inc", 32'(start_err_cnt), 32'd1);
    chk("parity_cnt_inc", 32'(parity_err_cnt), 32'd1);
    send_frame(8'h22, P_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    cnt_clear = 1'b1;
    @(negedge clock);
    cnt_clear = 1'b0;
    chk("clear_beats_inc", 32'(stop_err_cnt), 32'd0);
    chk("clear_start_cnt", 32'(start_err_cnt), 32'd0);
`endif

    repeat (3) @(negedge clock);
    chk("frame_count", 32'(n_fv), 32'(n_exp));
    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
